bcd_time_adjuster: RTL and testbench

// Clocked, parametrised successor to the combinational minute adjuster for the MM:SS timer.
// - Holds a 16-bit packed-BCD time value {M_tens, M_units, S_tens, S_units}.
// - Add/sub buttons step the selected field (seconds or minutes), with BCD carry/borrow.
// - Supports wrap or saturate at limits, and auto-repeat while a button is held.
// - Sits between the debounced button inputs and the countdown register's preset-load path.

---
 rtl/time_adj_pkg.sv | 32 +++
 rtl/bcd_digit_step.sv | 37 +++
 rtl/bcd_time_adjuster.sv | 217 +++++++++++++++++++++
 tb/tb_bcd_time_adjuster.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/time_adj_pkg.sv
// Shared types, constants and the preset clamp helper for the MM:SS time adjuster.
// Imported by bcd_digit_step and bcd_time_adjuster.
package time_adj_pkg;

  typedef enum logic [1:0] {IDLE, DELAY, REPEAT} adj_state_t;

  typedef struct packed {
    logic [3:0] mt;
    logic [3:0] mu;
    logic [3:0] st;
    logic [3:0] su;
  } bcd_time_t;

  localparam logic [7:0] SEC_MAX = 8'h59;

  localparam logic [1:0] ST_IDLE   = 2'(IDLE);
  localparam logic [1:0] ST_DELAY  = 2'(DELAY);
  localparam logic [1:0] ST_REPEAT = 2'(REPEAT);

  // Seconds tens above 5 count as malformed, so every stored value is a legal MM:SS.
  function automatic bcd_time_t clamp_load(input bcd_time_t t, input logic [7:0] max_min_bcd);
    logic bad;
    bad = (t.mt > 4'd9) | (t.mu > 4'd9) | (t.st > 4'd5) | (t.su > 4'd9) |
          ({t.mt, t.mu} > max_min_bcd);
    if (bad) begin
      return bcd_time_t'({max_min_bcd, SEC_MAX});
    end else begin
      return t;
    end
  endfunction

endpackage

// File: rtl/bcd_digit_step.sv
// One BCD digit of the time value: steps up or down by one with carry/borrow.
// Counts 0..max_digit; simultaneous inc and dec leave the digit unchanged.
module bcd_digit_step (
  input  logic [3:0] digit_in,
  input  logic       inc,
  input  logic       dec,
  input  logic [3:0] max_digit,
  output logic [3:0] digit_out,
  output logic       carry,
  output logic       borrow
);

  // Single-digit increment/decrement with roll-over flags
  always_comb begin
    digit_out = digit_in;
    carry     = 1'b0;
    borrow    = 1'b0;
    if (inc && !dec) begin
      if (digit_in >= max_digit) begin
        digit_out = 4'd0;
        carry     = 1'b1;
      end else begin
        digit_out = digit_in + 4'd1;
      end
    end else if (dec && !inc) begin
      if (digit_in == 4'd0) begin
        digit_out = max_digit;
        borrow    = 1'b1;
      end else begin
        digit_out = digit_in - 4'd1;
      end
    end else begin
      digit_out = digit_in;
    end
  end

endmodule

// File: rtl/bcd_time_adjuster.sv
// Clocked MM:SS packed-BCD preset adjuster: add/sub buttons step seconds or minutes,
// with auto-repeat while held and wrap or saturate at 00:00 / MAX_MIN:59.
module bcd_time_adjuster
  import time_adj_pkg::*;
#(
  parameter int MAX_MIN      = 59,
  parameter int WRAP_MODE    = 1,
  parameter int REPEAT_DELAY = 500,
  parameter int REPEAT_RATE  = 100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        add,
  input  logic        sub,
  input  logic        field_sel,
  input  logic        load,
  input  logic [15:0] in_time,
  output logic [15:0] time_out,
  output logic        step_pulse,
  output logic        limit
);

  // Counter sized for whichever interval is longer, so any legal REPEAT_RATE fits.
  localparam int CNT_TOP = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int CNT_W   = $clog2(CNT_TOP + 1);

  localparam logic [CNT_W-1:0] DELAY_CNT = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RATE_CNT  = CNT_W'(REPEAT_RATE);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [7:0]       MAX_BCD   = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
  localparam logic             WRAP_EN   = (WRAP_MODE != 0);

  bcd_time_t        time_q, time_d;
  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_q, dir_d;
  logic             add_q, add_d;
  logic             sub_q, sub_d;
  logic             lock_q, lock_d;
  logic             step_pulse_q, step_pulse_d;
  logic             limit_q, limit_d;

  logic       conflict_s, press_s, active_s, step_s, dir_s;
  logic       sec_inc_s, sec_dec_s, min_inc_s, min_dec_s;
  logic       su_c, su_b, st_c, st_b, mu_c, mu_b, mt_c, mt_b;
  logic       at_limit_s;
  bcd_time_t  stepped_s, limit_val_s;
  logic [7:0] min_s, sec_s;

  assign conflict_s = add & sub;
  assign press_s    = ((add & ~add_q) | (sub & ~sub_q)) & ~lock_q & ~conflict_s;
  assign active_s   = dir_q ? add : sub;

  // In IDLE the step direction comes straight from the pressed button.
  assign dir_s     = (state_q == ST_IDLE) ? add : dir_q;
  assign sec_inc_s = dir_s & ~field_sel;
  assign sec_dec_s = ~dir_s & ~field_sel;
  assign min_inc_s = dir_s & field_sel;
  assign min_dec_s = ~dir_s & field_sel;
  assign min_s     = {time_q.mt, time_q.mu};
  assign sec_s     = {time_q.st, time_q.su};

  bcd_digit_step u_su (
    .digit_in (time_q.su), .inc(sec_inc_s), .dec(sec_dec_s), .max_digit(4'd9),
    .digit_out(stepped_s.su), .carry(su_c), .borrow(su_b)
  );
  bcd_digit_step u_st (
    .digit_in (time_q.st), .inc(su_c), .dec(su_b), .max_digit(4'd5),
    .digit_out(stepped_s.st), .carry(st_c), .borrow(st_b)
  );
  bcd_digit_step u_mu (
    .digit_in (time_q.mu), .inc(min_inc_s | st_c), .dec(min_dec_s | st_b), .max_digit(4'd9),
    .digit_out(stepped_s.mu), .carry(mu_c), .borrow(mu_b)
  );
  bcd_digit_step u_mt (
    .digit_in (time_q.mt), .inc(mu_c), .dec(mu_b), .max_digit(4'd9),
    .digit_out(stepped_s.mt), .carry(mt_c), .borrow(mt_b)
  );

  // Limit detection: the digit chain only counts freely below MAX_MIN, so the
  // boundaries are caught here; a carry/borrow out of the top digit is folded in too.
  always_comb begin
    at_limit_s  = 1'b0;
    limit_val_s = time_q;
    case ({field_sel, dir_s})
      2'b01: begin
        at_limit_s  = ((min_s == MAX_BCD) && (sec_s == SEC_MAX)) | mt_c;
        limit_val_s = WRAP_EN ? bcd_time_t'(16'h0000) : time_q;
      end
      2'b00: begin
        at_limit_s  = (time_q == bcd_time_t'(16'h0000)) | mt_b;
        limit_val_s = WRAP_EN ? bcd_time_t'({MAX_BCD, SEC_MAX}) : time_q;
      end
      2'b11: begin
        at_limit_s  = (min_s == MAX_BCD) | mt_c;
        limit_val_s = WRAP_EN ? bcd_time_t'({8'h00, sec_s}) : time_q;
      end
      2'b10: begin
        at_limit_s  = (min_s == 8'h00) | mt_b;
        limit_val_s = WRAP_EN ? bcd_time_t'({MAX_BCD, sec_s}) : time_q;
      end
      default: begin
        at_limit_s  = 1'b0;
        limit_val_s = time_q;
      end
    endcase
  end

  // Press/hold FSM with the shared delay/rate counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    step_s  = 1'b0;
    if (load || conflict_s) begin
      state_d = ST_IDLE;
      cnt_d   = CNT_ZERO;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (press_s) begin
            step_s  = 1'b1;
            cnt_d   = CNT_ONE;
            dir_d   = add;
            state_d = ST_DELAY;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_DELAY: begin
          if (!active_s) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == DELAY_CNT) begin
            step_s  = 1'b1;
            cnt_d   = CNT_ONE;
            state_d = ST_REPEAT;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_REPEAT: begin
          if (!active_s) begin
            state_d = ST_IDLE;
            cnt_d   = CNT_ZERO;
          end else if (cnt_q == RATE_CNT) begin
            step_s = 1'b1;
            cnt_d  = CNT_ONE;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end
      endcase
    end
  end

  // A conflict locks out presses until both buttons have been released.
  always_comb begin
    add_d = add;
    sub_d = sub;
    if (conflict_s) begin
      lock_d = 1'b1;
    end else if (!add && !sub) begin
      lock_d = 1'b0;
    end else begin
      lock_d = lock_q;
    end
  end

  // Next time value and output pulses
  always_comb begin
    if (load) begin
      time_d = clamp_load(bcd_time_t'(in_time), MAX_BCD);
    end else if (step_s) begin
      time_d = at_limit_s ? limit_val_s : stepped_s;
    end else begin
      time_d = time_q;
    end
    step_pulse_d = step_s;
    limit_d      = step_s & at_limit_s;
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      time_q       <= bcd_time_t'(16'h0000);
      state_q      <= ST_IDLE;
      cnt_q        <= CNT_ZERO;
      dir_q        <= 1'b0;
      add_q        <= 1'b0;
      sub_q        <= 1'b0;
      lock_q       <= 1'b0;
      step_pulse_q <= 1'b0;
      limit_q      <= 1'b0;
    end else begin
      time_q       <= time_d;
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      dir_q        <= dir_d;
      add_q        <= add_d;
      sub_q        <= sub_d;
      lock_q       <= lock_d;
      step_pulse_q <= step_pulse_d;
      limit_q      <= limit_d;
    end
  end

  assign time_out   = time_q;
  assign step_pulse = step_pulse_q;
  assign limit      = limit_q;

endmodule

// File: tb/tb_bcd_time_adjuster.sv
// Bench for bcd_time_adjuster: a wrap instance (MAX_MIN=59) and a saturate instance
// (MAX_MIN=45) share stimulus and are compared every cycle against a behavioural model.
module tb_bcd_time_adjuster;

  localparam int RD   = 8;
  localparam int RR   = 4;
  localparam int MAXW = 59;
  localparam int MAXS = 45;

  logic        clk, rst_n, add, sub, field_sel, load;
  logic [15:0] in_time;
  logic [15:0] w_time, s_time;
  logic        w_pulse, w_limit, s_pulse, s_limit;

  int n_checks, n_pass;
  bit chk_en;

  // Model state: times as plain integers, hold tracked as age since the press.
  int mw, sw, ms, ss, m_age;
  bit p_add, p_sub, m_lock, m_held, m_dir;
  logic [15:0] exp_w_time, exp_s_time;
  logic        exp_pulse, exp_lim_w, exp_lim_s;

  bcd_time_adjuster #(.MAX_MIN(MAXW), .WRAP_MODE(1), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_w (
    .clk(clk), .rst_n(rst_n), .add(add), .sub(sub), .field_sel(field_sel), .load(load),
    .in_time(in_time), .time_out(w_time), .step_pulse(w_pulse), .limit(w_limit)
  );

  bcd_time_adjuster #(.MAX_MIN(MAXS), .WRAP_MODE(0), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut_s (
    .clk(clk), .rst_n(rst_n), .add(add), .sub(sub), .field_sel(field_sel), .load(load),
    .in_time(in_time), .time_out(s_time), .step_pulse(s_pulse), .limit(s_limit)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [15:0] to_bcd(input int m, input int s);
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  task automatic model_load(input logic [15:0] v, input int maxm, output int m, output int s);
    int a, b, c, d;
    a = int'(v[15:12]); b = int'(v[11:8]); c = int'(v[7:4]); d = int'(v[3:0]);
    if (a > 9 || b > 9 || c > 5 || d > 9 || a * 10 + b > maxm) begin
      m = maxm; s = 59;
    end else begin
      m = a * 10 + b; s = c * 10 + d;
    end
  endtask

  task automatic model_step(input int maxm, input bit wrap, input bit inc, input bit minf,
                            inout int m, inout int s, output bit lim);
    int tot, top;
    lim = 1'b0;
    if (!minf) begin
      tot = m * 60 + s;
      top = maxm * 60 + 59;
      if (inc) begin
        if (tot == top) begin lim = 1'b1; tot = wrap ? 0 : top; end
        else tot++;
      end else begin
        if (tot == 0) begin lim = 1'b1; tot = wrap ? top : 0; end
        else tot--;
      end
      m = tot / 60; s = tot % 60;
    end else begin
      if (inc) begin
        if (m == maxm) begin lim = 1'b1; if (wrap) m = 0; end
        else m++;
      end else begin
        if (m == 0) begin lim = 1'b1; if (wrap) m = maxm; end
        else m--;
      end
    end
  endtask

  task automatic model_reset();
    mw = 0; sw = 0; ms = 0; ss = 0; m_age = 0;
    p_add = 1'b0; p_sub = 1'b0; m_lock = 1'b0; m_held = 1'b0; m_dir = 1'b0;
    exp_w_time = 16'h0000; exp_s_time = 16'h0000;
    exp_pulse = 1'b0; exp_lim_w = 1'b0; exp_lim_s = 1'b0;
  endtask

  task automatic model_update();
    bit conflict, press, step, lw, ls;
    conflict = add && sub;
    press = ((add && !p_add) || (sub && !p_sub)) && !m_lock && !conflict;
    step = 1'b0; lw = 1'b0; ls = 1'b0;
    if (load || conflict) m_held = 1'b0;
    else if (m_held) begin
      if (!(m_dir ? add : sub)) m_held = 1'b0;
      else begin
        m_age++;
        if (m_age >= RD && (m_age - RD) % RR == 0) step = 1'b1;
      end
    end else if (press) begin
      m_held = 1'b1; m_dir = add; m_age = 0; step = 1'b1;
    end
    if (conflict) m_lock = 1'b1;
    else if (!add && !sub) m_lock = 1'b0;
    p_add = add; p_sub = sub;
    if (load) begin
      model_load(in_time, MAXW, mw, sw);
      model_load(in_time, MAXS, ms, ss);
    end else if (step) begin
      model_step(MAXW, 1'b1, m_dir, field_sel, mw, sw, lw);
      model_step(MAXS, 1'b0, m_dir, field_sel, ms, ss, ls);
    end
    exp_w_time = to_bcd(mw, sw);
    exp_s_time = to_bcd(ms, ss);
    exp_pulse  = step;
    exp_lim_w  = step && lw;
    exp_lim_s  = step && ls;
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
  endtask

  task automatic set_in(input bit l, input logic [15:0] v, input bit a, input bit s, input bit f);
    load = l; in_time = v; add = a; sub = s; field_sel = f;
  endtask

  // Cycle-by-cycle comparison of both instances against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("w_time", w_time, exp_w_time);
      chk("w_pulse", 16'(w_pulse), 16'(exp_pulse));
      chk("w_limit", 16'(w_limit), 16'(exp_lim_w));
      chk("s_time", s_time, exp_s_time);
      chk("s_pulse", 16'(s_pulse), 16'(exp_pulse));
      chk("s_limit", 16'(s_limit), 16'(exp_lim_s));
    end
  end

  initial begin
    int pulses;
    logic [1:0] btn;
    logic [15:0] v;
    bit ld;
    n_checks = 0; n_pass = 0; chk_en = 1'b0;
    rst_n = 1'b0;
    set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    model_reset();
    repeat (2) @(negedge clk);
    chk("reset_time", w_time, 16'h0000);
    chk("reset_pulse", 16'(w_pulse), 16'h0000);
    chk("reset_limit", 16'(s_limit), 16'h0000);
    chk_en = 1'b1;
    rst_n = 1'b1;
    cycle();

    // Seconds carry into minutes
    set_in(1'b1, 16'h0959, 1'b0, 1'b0, 1'b0); cycle();
    set_in(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0); cycle();
    chk("carry_time_w", w_time, 16'h1000);
    chk("carry_pulse_w", 16'(w_pulse), 16'h0001);
    chk("carry_limit_w", 16'(w_limit), 16'h0000);
    chk("carry_time_s", s_time, 16'h1000);
    set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); cycle();

    // Decrement below 00:00: wrap vs saturate
    set_in(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0); cycle();
    set_in(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0); cycle();
    chk("wrap_time_w", w_time, 16'h5959);
    chk("wrap_limit_w", 16'(w_limit), 16'h0001);
    chk("sat_time_s", s_time, 16'h0000);
    chk("sat_limit_s", 16'(s_limit), 16'h0001);
    chk("sat_pulse_s", 16'(s_pulse), 16'h0001);
    set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); cycle();

    // Auto-repeat on minutes: steps at 0, 8, 12, 16
    set_in(1'b1, 16'h0000, 1'b0, 1'b0, 1'b1); cycle();
    pulses = 0;
    for (int i = 0; i < 17; i++) begin
      set_in(1'b0, 16'h0000, 1'b1, 1'b0, 1'b1); cycle();
      if (w_pulse) pulses++;
    end
    chk("repeat_pulses", 16'(pulses), 16'd4);
    chk("repeat_time_w", w_time, 16'h0400);
    chk("repeat_time_s", s_time, 16'h0400);
    set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b1); cycle();

    // Load beats a simultaneous press; malformed preset is clamped
    set_in(1'b1, 16'h1234, 1'b1, 1'b0, 1'b0); cycle();
    chk("prio_time_w", w_time, 16'h1234);
    chk("prio_pulse_w", 16'(w_pulse), 16'h0000);
    set_in(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0); cycle();
    chk("prio_held_w", w_time, 16'h1234);
    set_in(1'b1, 16'h9999, 1'b0, 1'b0, 1'b0); cycle();
    chk("clamp_w", w_time, 16'h5959);
    chk("clamp_s", s_time, 16'h4559);
    set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); cycle();

    // Conflict: no step until both released and add rises again
    set_in(1'b1, 16'h1234, 1'b0, 1'b0, 1'b0); cycle();
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0); cycle();
      chk("conflict_time", w_time, 16'h1234);
    end
    for (int i = 0; i < 3; i++) begin
      set_in(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0); cycle();
      chk("conflict_hold", 16'(w_pulse), 16'h0000);
    end
    set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); cycle();
    set_in(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0); cycle();
    chk("rearm_time", w_time, 16'h1235);
    chk("rearm_pulse", 16'(w_pulse), 16'h0001);
    set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); cycle();

    // Async reset in the middle of a hold; held button is a fresh press afterwards
    set_in(1'b1, 16'h0000, 1'b0, 1'b0, 1'b0); cycle();
    for (int i = 0; i < 10; i++) begin
      set_in(1'b0, 16'h0000, 1'b1, 1'b0, 1'b0); cycle();
    end
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    chk("midreset_time_w", w_time, 16'h0000);
    chk("midreset_pulse_w", 16'(w_pulse), 16'h0000);
    chk("midreset_limit_w", 16'(w_limit), 16'h0000);
    chk("midreset_time_s", s_time, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    chk("post_reset_time", w_time, 16'h0001);
    chk("post_reset_pulse", 16'(w_pulse), 16'h0001);
    set_in(1'b0, 16'h0000, 1'b0, 1'b0, 1'b0); cycle();

    // Randomised buttons, field changes and presets
    btn = 2'b00;
    for (int c = 0; c < 4000; c++) begin
      if ($urandom_range(0, 11) == 0) begin
        int r;
        r = $urandom_range(0, 19);
        btn = (r < 7) ? 2'b00 : (r < 13) ? 2'b01 : (r < 19) ? 2'b10 : 2'b11;
      end
      if ($urandom_range(0, 19) == 0) field_sel = ~field_sel;
      ld = ($urandom_range(0, 29) == 0);
      v = 16'h0000;
      if (ld) begin
        if ($urandom_range(0, 3) != 0) begin
          v = to_bcd($urandom_range(0, 99), $urandom_range(0, 59));
        end else begin
          v = 16'($urandom);
          v[3:0] = 4'($urandom_range(10, 15));
        end
      end
      set_in(ld, v, btn[0], btn[1], field_sel);
      cycle();
    end

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
